// File: rtl/div_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_ctrl_pkg
// Description : Shared widths, M-extension divide opcodes, constants and the
//               divide-controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package div_ctrl_pkg;

  localparam int REG_BUS      = 32;
  localparam int REG_ADDR_BUS = 5;

  // funct3 encodings of the RV32M divide/remainder group
  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  localparam logic [REG_BUS-1:0]      ZERO_WORD = '0;
  localparam logic [REG_ADDR_BUS-1:0] ZERO_ADDR = '0;
  localparam logic [REG_BUS-1:0]      ALL_ONES  = '1;
  localparam logic [REG_BUS-1:0]      MIN_INT   = {1'b1, {(REG_BUS-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WB   = 2'd2
  } state_e;

endpackage : div_ctrl_pkg
`default_nettype wire

// File: rtl/div_special.sv
`default_nettype none
// ============================================================================
// Module      : div_special
// Description : Combinational detection of divide-by-zero and signed overflow
//               together with the architecturally fixed result.
// Revision    : 1.0 - initial release
// ============================================================================
module div_special
  import div_ctrl_pkg::*;
(
  input  logic [2:0]         op_i,
  input  logic [REG_BUS-1:0] dividend_i,
  input  logic [REG_BUS-1:0] divisor_i,
  output logic               special_o,
  output logic [REG_BUS-1:0] result_o
);

  logic w_is_rem;
  logic w_is_signed;
  logic w_div_zero;
  logic w_overflow;

  assign w_is_rem    = (op_i == INST_REM) || (op_i == INST_REMU);
  assign w_is_signed = (op_i == INST_DIV) || (op_i == INST_REM);
  assign w_div_zero  = (divisor_i == ZERO_WORD);
  // Only most-negative / -1 overflows, and only for the signed forms
  assign w_overflow  = w_is_signed && (dividend_i == MIN_INT) && (divisor_i == ALL_ONES);

  // Select the fixed result; divide-by-zero takes priority over overflow
  always_comb begin
    special_o = 1'b0;
    result_o  = ZERO_WORD;
    if (w_div_zero) begin
      special_o = 1'b1;
      result_o  = w_is_rem ? dividend_i : ALL_ONES;
    end else if (w_overflow) begin
      special_o = 1'b1;
      result_o  = w_is_rem ? ZERO_WORD : MIN_INT;
    end
  end

endmodule : div_special
`default_nettype wire

// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_ctrl
// Description : Pipeline-side controller for a multi-cycle divide unit.
//               Latches the request, short-circuits special cases, holds the
//               pipeline while the divider runs and issues one write-back.
// Revision    : 1.0 - initial release
// ============================================================================
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid_i,
  input  logic [2:0]              op_i,
  input  logic [REG_BUS-1:0]      dividend_i,
  input  logic [REG_BUS-1:0]      divisor_i,
  input  logic [REG_ADDR_BUS-1:0] rd_i,
  input  logic                    flush_i,
  output logic [REG_BUS-1:0]      div_dividend_o,
  output logic [REG_BUS-1:0]      div_divisor_o,
  output logic [2:0]              div_op_o,
  output logic [REG_ADDR_BUS-1:0] div_waddr_o,
  output logic                    div_start_o,
  input  logic [REG_BUS-1:0]      div_result_i,
  input  logic                    div_ready_i,
  input  logic                    div_busy_i,
  input  logic [REG_ADDR_BUS-1:0] div_waddr_i,
  output logic                    hold_o,
  output logic                    we_o,
  output logic [REG_ADDR_BUS-1:0] waddr_o,
  output logic [REG_BUS-1:0]      wdata_o
);

  state_e             state_q;
  logic               w_special;
  logic [REG_BUS-1:0] w_special_result;
  logic               w_ready_match;
  logic               w_unused_busy;

  // Completion is keyed on ready plus the echoed address; busy is informational
  assign w_unused_busy = div_busy_i;
  assign w_ready_match = div_ready_i && (div_waddr_i == div_waddr_o);

  div_special u_special (
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .special_o  (w_special),
    .result_o   (w_special_result)
  );

  // Controller FSM with registered divider-side and write-back outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      div_start_o    <= 1'b0;
      div_op_o       <= 3'b000;
      div_dividend_o <= ZERO_WORD;
      div_divisor_o  <= ZERO_WORD;
      div_waddr_o    <= ZERO_ADDR;
      we_o           <= 1'b0;
      waddr_o        <= ZERO_ADDR;
      wdata_o        <= ZERO_WORD;
    end else begin
      // Write port is only live for the single WB cycle
      we_o    <= 1'b0;
      waddr_o <= ZERO_ADDR;
      wdata_o <= ZERO_WORD;
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i && !flush_i) begin
            if (w_special) begin
              state_q <= ST_WB;
              we_o    <= (rd_i != ZERO_ADDR);
              waddr_o <= rd_i;
              wdata_o <= w_special_result;
            end else begin
              state_q        <= ST_RUN;
              div_start_o    <= 1'b1;
              div_op_o       <= op_i;
              div_dividend_o <= dividend_i;
              div_divisor_o  <= divisor_i;
              div_waddr_o    <= rd_i;
            end
          end
        end
        ST_RUN: begin
          // Flush wins over a coincident ready: the result is discarded
          if (flush_i) begin
            state_q     <= ST_IDLE;
            div_start_o <= 1'b0;
          end else if (w_ready_match) begin
            state_q     <= ST_WB;
            div_start_o <= 1'b0;
            we_o        <= (div_waddr_o != ZERO_ADDR);
            waddr_o     <= div_waddr_o;
            wdata_o     <= div_result_i;
          end
        end
        ST_WB: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q     <= ST_IDLE;
          div_start_o <= 1'b0;
        end
      endcase
    end
  end

  // Stall request: whole of RUN unless flushed, and the IDLE request cycle
  always_comb begin
    hold_o = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: hold_o = req_valid_i;
        ST_RUN:  hold_o = !flush_i;
        default: hold_o = 1'b0;
      endcase
    end
  end

endmodule : div_ctrl
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_ctrl
// Description : Directed self-checking bench for div_ctrl. The bench plays the
//               divide unit, returning hand-computed results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic [2:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic [31:0] div_dividend_o;
  logic [31:0] div_divisor_o;
  logic [2:0]  div_op_o;
  logic [4:0]  div_waddr_o;
  logic        div_start_o;
  logic [31:0] div_result_i;
  logic        div_ready_i;
  logic        div_busy_i;
  logic [4:0]  div_waddr_i;
  logic        hold_o;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;

  int checks = 0;
  int errors = 0;

  div_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid_i),
    .op_i           (op_i),
    .dividend_i     (dividend_i),
    .divisor_i      (divisor_i),
    .rd_i           (rd_i),
    .flush_i        (flush_i),
    .div_dividend_o (div_dividend_o),
    .div_divisor_o  (div_divisor_o),
    .div_op_o       (div_op_o),
    .div_waddr_o    (div_waddr_o),
    .div_start_o    (div_start_o),
    .div_result_i   (div_result_i),
    .div_ready_i    (div_ready_i),
    .div_busy_i     (div_busy_i),
    .div_waddr_i    (div_waddr_i),
    .hold_o         (hold_o),
    .we_o           (we_o),
    .waddr_o        (waddr_o),
    .wdata_o        (wdata_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present a request at the current negedge, then drop it at the next one
  task automatic do_req(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    req_valid_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; rd_i = rd;
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  // Pulse the divider's ready for one cycle with the given echo and result
  task automatic do_ready(input logic [4:0] rd, input logic [31:0] res);
    div_ready_i = 1'b1; div_waddr_i = rd; div_result_i = res; div_busy_i = 1'b0;
    @(negedge clk);
    div_ready_i = 1'b0; div_waddr_i = 5'd0; div_result_i = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid_i = 1'b1; op_i = INST_DIV; dividend_i = 32'd15; divisor_i = 32'd3;
    rd_i = 5'd12; flush_i = 1'b0; div_result_i = 32'd0; div_ready_i = 1'b0;
    div_busy_i = 1'b0; div_waddr_i = 5'd0;
    #1 rst = 1'b1;
    #2;
    checks++;
    if ({div_start_o, hold_o, we_o, waddr_o, wdata_o} !== {3'b000, 5'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_wb: start=%b hold=%b we=%b waddr=%0d wdata=%h, want all 0",
               div_start_o, hold_o, we_o, waddr_o, wdata_o);
    end
    checks++;
    if ({div_dividend_o, div_divisor_o, div_op_o, div_waddr_o} !== {32'd0, 32'd0, 3'd0, 5'd0}) begin
      errors++;
      $display("FAIL reset_div: dvd=%h dvs=%h op=%b waddr=%0d, want all 0",
               div_dividend_o, div_divisor_o, div_op_o, div_waddr_o);
    end
    @(negedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_div_normal();
    req_valid_i = 1'b1; op_i = INST_DIV; dividend_i = 32'd15; divisor_i = 32'd3; rd_i = 5'd12;
    #1;
    checks++;
    if (hold_o !== 1'b1 || div_start_o !== 1'b0) begin
      errors++;
      $display("FAIL norm_req: hold=%b start=%b, want 1 0", hold_o, div_start_o);
    end
    @(negedge clk);
    req_valid_i = 1'b0;
    checks++;
    if ({div_start_o, div_op_o, div_dividend_o, div_divisor_o, div_waddr_o, hold_o}
        !== {1'b1, INST_DIV, 32'd15, 32'd3, 5'd12, 1'b1}) begin
      errors++;
      $display("FAIL norm_run: start=%b op=%b dvd=%0d dvs=%0d waddr=%0d hold=%b, want 1 100 15 3 12 1",
               div_start_o, div_op_o, div_dividend_o, div_divisor_o, div_waddr_o, hold_o);
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        req_valid_i = 1'b1; op_i = INST_REMU; dividend_i = 32'd99; divisor_i = 32'd7; rd_i = 5'd3;
      end
      if (i == 1) begin
        req_valid_i = 1'b0; div_ready_i = 1'b1; div_waddr_i = 5'd13; div_result_i = 32'hDEAD;
      end
      if (i == 2) begin
        div_ready_i = 1'b0; div_waddr_i = 5'd0; div_result_i = 32'd0;
      end
      @(negedge clk);
      checks++;
      if (div_start_o !== 1'b1 || div_dividend_o !== 32'd15 || div_divisor_o !== 32'd3 ||
          div_op_o !== INST_DIV || div_waddr_o !== 5'd12 || we_o !== 1'b0 || hold_o !== 1'b1) begin
        errors++;
        $display("FAIL norm_stable[%0d]: start=%b dvd=%0d dvs=%0d op=%b waddr=%0d we=%b hold=%b, want 1 15 3 100 12 0 1",
                 i, div_start_o, div_dividend_o, div_divisor_o, div_op_o, div_waddr_o, we_o, hold_o);
      end
    end
    do_ready(5'd12, 32'd5);
    checks++;
    if ({we_o, waddr_o, wdata_o, div_start_o, hold_o} !== {1'b1, 5'd12, 32'd5, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL norm_wb: we=%b waddr=%0d wdata=%h start=%b hold=%b, want 1 12 5 0 0",
               we_o, waddr_o, wdata_o, div_start_o, hold_o);
    end
    @(negedge clk);
    checks++;
    if (we_o !== 1'b0 || div_start_o !== 1'b0) begin
      errors++;
      $display("FAIL norm_after: we=%b start=%b, want 0 0", we_o, div_start_o);
    end
  endtask

  task automatic test_rem();
    do_req(INST_REM, 32'hFFFF_FFF9, 32'd2, 5'd5);
    checks++;
    if (div_start_o !== 1'b1 || div_op_o !== INST_REM) begin
      errors++;
      $display("FAIL rem_start: start=%b op=%b, want 1 110", div_start_o, div_op_o);
    end
    @(negedge clk);
    do_ready(5'd5, 32'hFFFF_FFFF);
    checks++;
    if ({we_o, waddr_o, wdata_o} !== {1'b1, 5'd5, 32'hFFFF_FFFF}) begin
      errors++;
      $display("FAIL rem_wb: we=%b waddr=%0d wdata=%h, want 1 5 ffffffff", we_o, waddr_o, wdata_o);
    end
    @(negedge clk);
    do_req(INST_REMU, 32'd7, 32'd2, 5'd6);
    do_ready(5'd6, 32'd1);
    checks++;
    if ({we_o, waddr_o, wdata_o} !== {1'b1, 5'd6, 32'd1}) begin
      errors++;
      $display("FAIL remu_wb: we=%b waddr=%0d wdata=%h, want 1 6 1", we_o, waddr_o, wdata_o);
    end
    @(negedge clk);
  endtask

  task automatic test_div_zero();
    do_req(INST_DIVU, 32'd100, 32'd0, 5'd7);
    checks++;
    if ({we_o, waddr_o, wdata_o, div_start_o, hold_o} !== {1'b1, 5'd7, 32'hFFFF_FFFF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL divu0_wb: we=%b waddr=%0d wdata=%h start=%b hold=%b, want 1 7 ffffffff 0 0",
               we_o, waddr_o, wdata_o, div_start_o, hold_o);
    end
    @(negedge clk);
    checks++;
    if (we_o !== 1'b0 || div_start_o !== 1'b0) begin
      errors++;
      $display("FAIL divu0_after: we=%b start=%b, want 0 0", we_o, div_start_o);
    end
    do_req(INST_REMU, 32'd100, 32'd0, 5'd8);
    checks++;
    if ({we_o, waddr_o, wdata_o, div_start_o} !== {1'b1, 5'd8, 32'd100, 1'b0}) begin
      errors++;
      $display("FAIL remu0_wb: we=%b waddr=%0d wdata=%h start=%b, want 1 8 100 0",
               we_o, waddr_o, wdata_o, div_start_o);
    end
    @(negedge clk);
    do_req(INST_DIV, 32'h1234, 32'd0, 5'd0);
    checks++;
    if ({we_o, wdata_o, div_start_o} !== {1'b0, 32'hFFFF_FFFF, 1'b0}) begin
      errors++;
      $display("FAIL div0_x0: we=%b wdata=%h start=%b, want 0 ffffffff 0", we_o, wdata_o, div_start_o);
    end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    do_req(INST_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    checks++;
    if ({we_o, waddr_o, wdata_o, div_start_o} !== {1'b1, 5'd9, 32'h8000_0000, 1'b0}) begin
      errors++;
      $display("FAIL ovf_div: we=%b waddr=%0d wdata=%h start=%b, want 1 9 80000000 0",
               we_o, waddr_o, wdata_o, div_start_o);
    end
    @(negedge clk);
    do_req(INST_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    checks++;
    if ({we_o, waddr_o, wdata_o, div_start_o} !== {1'b1, 5'd10, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL ovf_rem: we=%b waddr=%0d wdata=%h start=%b, want 1 10 0 0",
               we_o, waddr_o, wdata_o, div_start_o);
    end
    @(negedge clk);
    // Unsigned form of the same operands is an ordinary divide
    do_req(INST_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    checks++;
    if (div_start_o !== 1'b1 || we_o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_divu_run: start=%b we=%b, want 1 0", div_start_o, we_o);
    end
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
  endtask

  task automatic test_flush();
    int writes;
    do_req(INST_DIV, 32'd15, 32'd3, 5'd12);
    @(negedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    #1;
    checks++;
    if (hold_o !== 1'b0 || div_start_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_hold: hold=%b start=%b, want 0 1", hold_o, div_start_o);
    end
    @(negedge clk);
    flush_i = 1'b0;
    checks++;
    if ({div_start_o, we_o, hold_o} !== 3'b000) begin
      errors++;
      $display("FAIL flush_next: start=%b we=%b hold=%b, want 0 0 0", div_start_o, we_o, hold_o);
    end
    writes = 0;
    div_ready_i = 1'b1; div_waddr_i = 5'd12; div_result_i = 32'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      div_ready_i = 1'b0;
      if (we_o === 1'b1) writes++;
    end
    checks++;
    if (writes !== 0) begin
      errors++;
      $display("FAIL flush_late_ready: writes=%0d, want 0", writes);
    end
    // Flush coincident with a request in IDLE discards it
    flush_i = 1'b1;
    do_req(INST_DIV, 32'd15, 32'd3, 5'd12);
    flush_i = 1'b0;
    checks++;
    if (div_start_o !== 1'b0 || we_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_req: start=%b we=%b, want 0 0", div_start_o, we_o);
    end
    @(negedge clk);
  endtask

  task automatic test_flush_wb();
    do_req(INST_DIVU, 32'd5, 32'd0, 5'd4);
    flush_i = 1'b1;
    #1;
    checks++;
    if ({we_o, waddr_o, wdata_o} !== {1'b1, 5'd4, 32'hFFFF_FFFF}) begin
      errors++;
      $display("FAIL flush_wb: we=%b waddr=%0d wdata=%h, want 1 4 ffffffff", we_o, waddr_o, wdata_o);
    end
    @(negedge clk);
    flush_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int writes;
    do_req(INST_DIV, 32'd15, 32'd3, 5'd12);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({div_start_o, hold_o, div_dividend_o} !== {1'b0, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL rst_mid: start=%b hold=%b dvd=%h, want 0 0 0", div_start_o, hold_o, div_dividend_o);
    end
    @(negedge clk);
    rst = 1'b0;
    do_ready(5'd12, 32'hBAD);
    checks++;
    if (we_o !== 1'b0 || div_start_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_stale_ready: we=%b start=%b, want 0 0", we_o, div_start_o);
    end
    do_req(INST_DIV, 32'd15, 32'd3, 5'd12);
    @(negedge clk);
    writes = 0;
    do_ready(5'd12, 32'd5);
    checks++;
    if ({we_o, waddr_o, wdata_o} !== {1'b1, 5'd12, 32'd5}) begin
      errors++;
      $display("FAIL rst_new_wb: we=%b waddr=%0d wdata=%h, want 1 12 5", we_o, waddr_o, wdata_o);
    end
    for (int i = 0; i < 4; i++) begin
      if (we_o === 1'b1) writes++;
      @(negedge clk);
    end
    checks++;
    if (writes !== 1) begin
      errors++;
      $display("FAIL rst_write_count: writes=%0d, want 1", writes);
    end
  endtask

  initial begin
    test_reset();
    test_div_normal();
    test_rem();
    test_div_zero();
    test_overflow();
    test_flush();
    test_flush_wb();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_div_ctrl
`default_nettype wire
